wb_load_store_unit: RTL

- Parametrised Wishbone B4 pipelined bus master for CPU fetch and load/store traffic; successor of the single-width fetch/memory unit.
- Adds byte/half/word access with byte selects and lane steering, and zero/sign extension on reads.
- Adds stall handling, a bus-error input, a watchdog timeout and a misalignment check, each reported as an error code.
- The CPU instantiates it between the execute and commit stages and, separately, as the instruction fetcher.

---
 rtl/wb_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_load_store_unit.sv
// Wishbone B4 pipelined load/store master: byte/half/word(/dword) accesses with
// lane steering, load extension, and bus-error / timeout / alignment reporting.
module wb_load_store_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_enable,
  input  logic                    i_we,
  input  logic [1:0]              i_size,
  input  logic                    i_signed,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_completed,
  output logic                    o_error,
  output logic [1:0]              o_err_code,
  output logic                    o_busy,
  output logic [ADDR_WIDTH-1:0]   o_wb_addr,
  output logic [DATA_WIDTH-1:0]   o_wb_data,
  output logic [DATA_WIDTH/8-1:0] o_wb_sel,
  output logic                    o_wb_we,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  input  logic [DATA_WIDTH-1:0]   i_wb_data,
  input  logic                    i_wb_ack,
  input  logic                    i_wb_err,
  input  logic                    i_wb_stall
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned LSB       = $clog2(SEL_WIDTH);
  localparam bit          DWORD_OK  = (DATA_WIDTH == 64);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BUS     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ALIGN   = 2'b11;

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Byte-lane mask: (1 << (1 << size)) - 1, shifted to the lane offset.
  function automatic logic [SEL_WIDTH-1:0] lane_sel(input logic [1:0] size,
                                                    input logic [LSB-1:0] off);
    logic [SEL_WIDTH-1:0] s;
    int                   nb;
    nb = 1 << size;
    s  = '0;
    for (int i = 0; i < int'(SEL_WIDTH); i++) begin
      s[i] = (i >= int'(off)) && (i < int'(off) + nb);
    end
    return s;
  endfunction

  // Copies the right-justified store datum into every lane.
  function automatic logic [DATA_WIDTH-1:0] replicate(input logic [1:0] size,
                                                      input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    int                    nbits;
    nbits = 8 << size;
    if (nbits > int'(DATA_WIDTH)) nbits = int'(DATA_WIDTH);
    r = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      r[i] = d[i % nbits];
    end
    return r;
  endfunction

  // Zero- or sign-extends the low (8 << size) bits of an already shifted read.
  function automatic logic [DATA_WIDTH-1:0] extend(input logic [1:0] size,
                                                   input logic sgn,
                                                   input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    logic                  fill;
    int                    nbits;
    nbits = 8 << size;
    if (nbits > int'(DATA_WIDTH)) nbits = int'(DATA_WIDTH);
    fill = sgn & d[nbits-1];
    r    = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      r[i] = (i < nbits) ? d[i] : fill;
    end
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [LSB-1:0]          lo_q, lo_d;
  logic [1:0]              size_q, size_d;
  logic                    signed_q, signed_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]              code_q, code_d;

  logic [DATA_WIDTH-1:0]   rdata_d;
  logic                    completed_d, error_d, busy_d;
  logic [1:0]              err_code_d;
  logic [ADDR_WIDTH-1:0]   wb_addr_d;
  logic [DATA_WIDTH-1:0]   wb_data_d;
  logic [SEL_WIDTH-1:0]    wb_sel_d;
  logic                    wb_we_d, wb_cyc_d, wb_stb_d;

  logic                    req_illegal;
  logic                    finish;
  logic [1:0]              finish_code;

  always_comb begin
    req_illegal = ((i_size == 2'd3) && !DWORD_OK) ||
                  ((i_addr[LSB-1:0] & LSB'((1 << i_size) - 1)) != '0);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    size_d      = size_q;
    signed_d    = signed_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    rdata_d     = o_rdata;
    completed_d = 1'b0;
    error_d     = 1'b0;
    err_code_d  = o_err_code;
    busy_d      = o_busy;
    wb_addr_d   = o_wb_addr;
    wb_data_d   = o_wb_data;
    wb_sel_d    = o_wb_sel;
    wb_we_d     = o_wb_we;
    wb_cyc_d    = o_wb_cyc;
    wb_stb_d    = o_wb_stb;
    finish      = 1'b0;
    finish_code = ERR_OK;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (i_enable && !o_busy) begin
          busy_d   = 1'b1;
          lo_d     = i_addr[LSB-1:0];
          size_d   = i_size;
          signed_d = i_signed;
          wb_we_d  = i_we;
          if (req_illegal) begin
            code_d  = ERR_ALIGN;
            state_d = ST_DONE;
          end else begin
            code_d    = ERR_OK;
            cnt_d     = '0;
            state_d   = ST_REQ;
            wb_cyc_d  = 1'b1;
            wb_stb_d  = 1'b1;
            wb_addr_d = {i_addr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
            wb_data_d = replicate(i_size, i_wdata);
            wb_sel_d  = lane_sel(i_size, i_addr[LSB-1:0]);
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        if (!i_wb_stall) begin
          wb_stb_d = 1'b0;
          state_d  = ST_WAIT;
          if (i_wb_err) begin
            finish      = 1'b1;
            finish_code = ERR_BUS;
          end else if (i_wb_ack) begin
            finish = 1'b1;
          end
        end
        if (!finish && (cnt_q == CNT_LAST)) begin
          finish      = 1'b1;
          finish_code = ERR_TIMEOUT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        if (i_wb_err) begin
          finish      = 1'b1;
          finish_code = ERR_BUS;
        end else if (i_wb_ack) begin
          finish = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          finish      = 1'b1;
          finish_code = ERR_TIMEOUT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        // Rejected requests never touched the bus; they report from here.
        if (code_q == ERR_ALIGN) begin
          completed_d = 1'b1;
          error_d     = 1'b1;
          err_code_d  = ERR_ALIGN;
        end else begin
          busy_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d     = ST_DONE;
      wb_cyc_d    = 1'b0;
      wb_stb_d    = 1'b0;
      completed_d = 1'b1;
      error_d     = (finish_code != ERR_OK);
      err_code_d  = finish_code;
      code_d      = finish_code;
      if ((finish_code == ERR_OK) && !o_wb_we) begin
        rdata_d = extend(size_q, signed_q, i_wb_data >> {lo_q, 3'b000});
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lo_q        <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      cnt_q       <= '0;
      code_q      <= ERR_OK;
      o_rdata     <= '0;
      o_completed <= 1'b0;
      o_error     <= 1'b0;
      o_err_code  <= '0;
      o_busy      <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
      o_wb_sel    <= '0;
      o_wb_we     <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      o_rdata     <= rdata_d;
      o_completed <= completed_d;
      o_error     <= error_d;
      o_err_code  <= err_code_d;
      o_busy      <= busy_d;
      o_wb_addr   <= wb_addr_d;
      o_wb_data   <= wb_data_d;
      o_wb_sel    <= wb_sel_d;
      o_wb_we     <= wb_we_d;
      o_wb_cyc    <= wb_cyc_d;
      o_wb_stb    <= wb_stb_d;
    end
  end

endmodule
